// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder, one SEG_WIDTH-bit segment per stage.
// Define CLA_SUB_EN to add a sub input (A-B via inverted B and carry-in).
module pipelined_cla_adder #(
    parameter int WIDTH     = 32,
    parameter int SEG_WIDTH = 8
) (
    input  logic             clk,
    input  logic             clear_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef CLA_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             C_out,
    output logic             overflow,
    output logic             zero
);
    localparam int NSEG = WIDTH / SEG_WIDTH;
    localparam int SW   = SEG_WIDTH;

    // Returns {carry into MSB, carry out, sum}; 4-bit lookahead groups.
    function automatic logic [SW+1:0] cla_seg(
        input logic [SW-1:0] a,
        input logic [SW-1:0] b,
        input logic          ci
    );
        logic [SW-1:0] g;
        logic [SW-1:0] p;
        logic [SW:0]   c;
        g    = a & b;
        p    = a ^ b;
        c    = '0;
        c[0] = ci;
        for (int j = 0; j < SW; j += 4) begin
            c[j+1] = g[j] | (p[j] & c[j]);
            c[j+2] = g[j+1] | (p[j+1] & g[j])
                   | (p[j+1] & p[j] & c[j]);
            c[j+3] = g[j+2] | (p[j+2] & g[j+1])
                   | (p[j+2] & p[j+1] & g[j])
                   | (p[j+2] & p[j+1] & p[j] & c[j]);
            c[j+4] = g[j+3] | (p[j+3] & g[j+2])
                   | (p[j+3] & p[j+2] & g[j+1])
                   | (p[j+3] & p[j+2] & p[j+1] & g[j])
                   | (p[j+3] & p[j+2] & p[j+1] & p[j] & c[j]);
        end
        return {c[SW-1], c[SW], p ^ c[SW-1:0]};
    endfunction

    logic                       sub_w;
    logic                       advance;
    logic [NSEG-1:0]            vld_q;
    logic [NSEG-1:0]            c_q;
    logic [NSEG-1:0]            c_d;
    logic [NSEG-1:0][WIDTH-1:0] a_q;
    logic [NSEG-1:0][WIDTH-1:0] b_q;
    logic [NSEG-1:0][WIDTH-1:0] s_q;
    logic [NSEG-1:0][WIDTH-1:0] s_d;
    logic                       ovf_q;
    logic                       ovf_d;
    logic                       zero_q;
    logic                       zero_d;
    logic                       cmsb;
    logic [SW+1:0]              seg;
    logic [NSEG:0]              vld_in;
    logic [NSEG:0]              c_in;
    logic [NSEG:0][WIDTH-1:0]   a_in;
    logic [NSEG:0][WIDTH-1:0]   b_in;
    logic [NSEG:0][WIDTH-1:0]   s_in;
    logic                       unused;

`ifdef CLA_SUB_EN
    assign sub_w = sub;
`else
    assign sub_w = 1'b0;
`endif

    // Index k is the input of stage k; index 0 comes from the ports.
    assign vld_in = {vld_q, in_valid};
    assign a_in   = {a_q, A};
    assign b_in   = {b_q, B ^ {WIDTH{sub_w}}};
    assign c_in   = {c_q, Cin ^ sub_w};
    assign s_in   = {s_q, {WIDTH{1'b0}}};
    assign unused = ^{vld_in[NSEG], a_in[NSEG], b_in[NSEG],
                      c_in[NSEG], s_in[NSEG]};

    assign advance  = out_ready | ~vld_q[NSEG-1];
    assign in_ready = advance;

    always_comb begin
        s_d  = s_in[NSEG-1:0];
        c_d  = '0;
        cmsb = 1'b0;
        seg  = '0;
        for (int k = 0; k < NSEG; k++) begin
            seg = cla_seg(a_in[k][k*SW +: SW],
                          b_in[k][k*SW +: SW], c_in[k]);
            s_d[k][k*SW +: SW] = seg[SW-1:0];
            c_d[k] = seg[SW];
            if (k == NSEG - 1) cmsb = seg[SW+1];
        end
        ovf_d  = cmsb ^ c_d[NSEG-1];
        zero_d = ~|s_d[NSEG-1];
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            vld_q  <= '0;
            a_q    <= '0;
            b_q    <= '0;
            s_q    <= '0;
            c_q    <= '0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (advance) begin
            vld_q  <= vld_in[NSEG-1:0];
            a_q    <= a_in[NSEG-1:0];
            b_q    <= b_in[NSEG-1:0];
            s_q    <= s_d;
            c_q    <= c_d;
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = vld_q[NSEG-1];
    assign S         = s_q[NSEG-1];
    assign C_out     = c_q[NSEG-1];
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule
